sdram_bus_arbiter: RTL and testbench
====================================

# sdram_bus_arbiter

Parametrised N-port front end for the SDRAM controller's native system bus: several bus masters (JTAG host, traffic generator, CPU) share one `sdram_IS42S16400` instance. Round-robin arbitration grants one master at a time, holds the grant through a write burst, and records each accepted read in a tag FIFO. Returned read beats are routed back to the originating port in order. Sits between the masters and the controller in the FPGA top level.

## Interface
- `NPORT`, 4: number of upstream masters (2..8)
- `AW`, 23: address width
- `DW`, 16: data width; byte-enable width is `DW/8`
- `DEPTH`, 8: outstanding-read tag FIFO depth (power of 2)
- `clk` in 1: single clock for all logic
- `rst` in 1: asynchronous, active-high reset
- `up_read` in NPORT: per-port read request, held until accepted
- `up_write` in NPORT: per-port write request, held until accepted
- `up_addr` in NPORT×AW: per-port address
- `up_burst` in NPORT: per-port burst enable
- `up_burst_len` in NPORT×3: burst code; 0/1/2/3 give 1/2/4/8 beats, 4..7 give 8
- `up_wdata` in NPORT×DW: per-port write data
- `up_byteenable` in NPORT×DW/8: per-port byte enables
- `up_ready` out NPORT: accept strobe, only toward the granted port
- `up_rvalid` out NPORT: read-data valid, only toward the owning port
- `up_rdata` out DW: read data, broadcast to all ports
- `bus_read`, `bus_write`, `bus_addr`, `bus_burst`, `bus_burst_len`, `bus_wdata`, `bus_byteenable` out: downstream request (controller widths)
- `bus_ready` in 1: downstream accept
- `bus_rvalid` in 1: downstream read beat valid
- `bus_rdata` in DW: downstream read data
- `err_orphan_rvalid` out 1: sticky; `bus_rvalid` seen while the tag FIFO is empty

## Operation
- State machine has two states: IDLE and GRANT.
- **IDLE**
  - Request vector: `req[i] = up_read[i] | up_write[i]`.
  - A port with `up_read` asserted is masked from `req` while the tag FIFO is full.
  - Round-robin: the search starts at `last_grant+1` and wraps. `last_grant` resets to `NPORT-1`, so port 0 has first priority.
  - On any unmasked request: register `grant` and `last_grant` = winner, register the beat count, go to GRANT.
- **GRANT**
  - Downstream request signals are a combinational mux of the granted port's inputs.
  - `up_ready[grant] = bus_ready`; all other `up_ready` bits are 0.
- **Read acceptance** (`bus_read & bus_ready`)
  - Push {port = grant, beats} into the tag FIFO.
  - Return to IDLE.
- **Write acceptance** (`bus_write & bus_ready`)
  - Decrement the beat counter.
  - On the last beat, return to IDLE. Otherwise stay in GRANT: the port must supply the next beat, with its wdata and byteenable.
- **Beat count:** `bus_burst ? 1<<min(code,3) : 1`.
- **Dropped request:** if the granted port deasserts both read and write before acceptance, return to IDLE without pushing or counting (protocol violation, tolerated).
- **Read return**
  - `up_rvalid[head.port] = bus_rvalid`.
  - Each `bus_rvalid` decrements the head beat counter. The last beat pops the entry.
- **Simultaneous events:** a push and a pop in the same cycle are both performed; occupancy is unchanged.
- **Orphan beat:** `bus_rvalid` with an empty FIFO sets `err_orphan_rvalid` and is dropped. It is cleared only by `rst`.
- **Reset mid-operation:** state goes to IDLE, FIFO empties, counters clear. In-flight downstream reads are lost; the caller resets the controller together with the arbiter.

## Timing
- Reset values:
  - All `up_ready`, `up_rvalid`, `bus_read`, `bus_write`, `bus_burst`, `err_orphan_rvalid` are 0.
  - `bus_addr`, `bus_wdata`, `bus_burst_len`, `bus_byteenable`, `up_rdata` are 0.
- Grant latency: request at cycle N in IDLE → downstream request visible at cycle N+1.
- After a request completes there is one IDLE bubble cycle before the next grant. Peak throughput is therefore one request per 2 cycles.
- `bus_ready` → `up_ready` is combinational, zero cycles.
- `bus_rvalid`/`bus_rdata` → `up_rvalid`/`up_rdata` is combinational, zero cycles.
- The full-mask uses registered occupancy. A pop in the same cycle does not unmask a read until the next cycle.

## Structure
- Package `sdram_bus_pkg`:
  - `beats_f(burst, code)` function
  - `tag_t` struct: port index `$clog2(NPORT)`, beat count 4 bits
  - state enum
- Sub-module `sdram_tag_fifo`: synchronous FIFO of `tag_t`, `DEPTH` entries, with full/empty flags. Push and pop in the same cycle are legal.

## Test plan
- Ports 0 and 2 both issue a single write at cycle 1 with `bus_ready` always 1 → port 0 is accepted at cycle 2 and port 2 at cycle 4. No back-to-back grant to the same port while the other is waiting.
- Port 1 writes a 4-beat burst (`up_burst=1`, code 2) while port 3 requests → port 3 is not granted until all 4 port-1 beats are accepted.
- Port 3 reads with code 3; the controller returns 8 `bus_rvalid` beats of 0x1000..0x1007 → only `up_rvalid[3]` pulses 8 times with matching data; the FIFO is empty afterwards.
- `DEPTH=2`, three reads accepted with `bus_rvalid` held off → the third read is not granted and port 0's pending write still proceeds. The first return beat unmasks the read one cycle later.
- Interleaved single reads from ports 0, 1, 0 → return beats are routed to 0, 1, 0 in order.
- `bus_rvalid` pulsed with nothing outstanding → `err_orphan_rvalid` rises the next cycle and stays high until `rst`. `rst` pulsed mid-burst → all outputs return to 0 asynchronously.

Source files
------------

// File: rtl/sdram_bus_pkg.sv
// Shared types for the SDRAM bus arbiter: read tag record, FSM state, burst decode.
package sdram_bus_pkg;

  localparam int PORT_W = 3;  // covers up to 8 upstream ports
  localparam int BEAT_W = 4;

  typedef struct packed {
    logic [PORT_W-1:0] port;
    logic [BEAT_W-1:0] beats;
  } tag_t;

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_GRANT = 1'b1
  } state_e;

  // Codes above 3 saturate at 8 beats.
  function automatic logic [BEAT_W-1:0] beats_f(input logic burst, input logic [2:0] code);
    logic [BEAT_W-1:0] n;
    if (!burst) begin
      n = 4'd1;
    end else begin
      case (code)
        3'd0:    n = 4'd1;
        3'd1:    n = 4'd2;
        3'd2:    n = 4'd4;
        default: n = 4'd8;
      endcase
    end
    return n;
  endfunction

endpackage

// File: rtl/sdram_tag_fifo.sv
// Synchronous FIFO of outstanding-read tags; push and pop may coincide.
module sdram_tag_fifo
  import sdram_bus_pkg::*;
#(
  parameter int DEPTH = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic push_i,
  input  tag_t din_i,
  input  logic pop_i,
  output tag_t dout_o,
  output logic full_o,
  output logic empty_o
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  logic [PW-1:0] wr_q, rd_q;
  logic [PW:0]   cnt_q;
  tag_t          mem_q [DEPTH];
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == FULL_CNT);
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign dout_o  = mem_q[rd_q];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      case ({push_ok, pop_ok})
        2'b10:   cnt_q <= cnt_q + 1'b1;
        2'b01:   cnt_q <= cnt_q - 1'b1;
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only read while occupancy covers them.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= din_i;
  end

endmodule

// File: rtl/sdram_bus_arbiter.sv
// Round-robin N-port front end for the SDRAM controller bus; holds grant through
// write bursts and routes read beats back to their requester via a tag FIFO.
module sdram_bus_arbiter
  import sdram_bus_pkg::*;
#(
  parameter int NPORT = 4,
  parameter int AW    = 23,
  parameter int DW    = 16,
  parameter int DEPTH = 8
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NPORT-1:0]         up_read,
  input  logic [NPORT-1:0]         up_write,
  input  logic [NPORT*AW-1:0]      up_addr,
  input  logic [NPORT-1:0]         up_burst,
  input  logic [NPORT*3-1:0]       up_burst_len,
  input  logic [NPORT*DW-1:0]      up_wdata,
  input  logic [NPORT*(DW/8)-1:0]  up_byteenable,
  output logic [NPORT-1:0]         up_ready,
  output logic [NPORT-1:0]         up_rvalid,
  output logic [DW-1:0]            up_rdata,
  output logic                     bus_read,
  output logic                     bus_write,
  output logic [AW-1:0]            bus_addr,
  output logic                     bus_burst,
  output logic [2:0]               bus_burst_len,
  output logic [DW-1:0]            bus_wdata,
  output logic [DW/8-1:0]          bus_byteenable,
  input  logic                     bus_ready,
  input  logic                     bus_rvalid,
  input  logic [DW-1:0]            bus_rdata,
  output logic                     err_orphan_rvalid
);

  localparam int BW = DW / 8;

  state_e              state_q, state_d;
  logic [PORT_W-1:0]   grant_q, grant_d;   // doubles as last_grant while idle
  logic [BEAT_W-1:0]   beats_q, beats_d;
  logic [BEAT_W-1:0]   rx_cnt_q, rx_cnt_d;
  logic                err_q, err_d;

  logic [NPORT-1:0]    req;
  logic                found;
  logic [PORT_W-1:0]   win;
  logic                win_burst;
  logic [2:0]          win_len;

  logic                sel_read, sel_write, sel_burst;
  logic [AW-1:0]       sel_addr;
  logic [2:0]          sel_len;
  logic [DW-1:0]       sel_wdata;
  logic [BW-1:0]       sel_be;

  logic                fifo_push, fifo_pop, fifo_full, fifo_empty, rv_ok;
  tag_t                head;

  sdram_tag_fifo #(.DEPTH(DEPTH)) u_tag_fifo (
    .clk     (clk),
    .rst     (rst),
    .push_i  (fifo_push),
    .din_i   ('{port: grant_q, beats: beats_q}),
    .pop_i   (fifo_pop),
    .dout_o  (head),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Reads are masked on registered occupancy, so a same-cycle pop unmasks next cycle.
  always_comb begin
    req       = '0;
    found     = 1'b0;
    win       = '0;
    win_burst = 1'b0;
    win_len   = '0;
    for (int i = 0; i < NPORT; i++) begin
      req[i] = (up_read[i] | up_write[i]) & ~(up_read[i] & fifo_full);
    end
    for (int k = 1; k <= NPORT; k++) begin
      for (int i = 0; i < NPORT; i++) begin
        if (!found && req[i] && (((int'(grant_q) + k) % NPORT) == i)) begin
          found     = 1'b1;
          win       = PORT_W'(i);
          win_burst = up_burst[i];
          win_len   = up_burst_len[i*3 +: 3];
        end
      end
    end
  end

  always_comb begin
    sel_read  = 1'b0;
    sel_write = 1'b0;
    sel_burst = 1'b0;
    sel_addr  = '0;
    sel_len   = '0;
    sel_wdata = '0;
    sel_be    = '0;
    for (int i = 0; i < NPORT; i++) begin
      if (grant_q == PORT_W'(i)) begin
        sel_read  = up_read[i];
        sel_write = up_write[i];
        sel_burst = up_burst[i];
        sel_addr  = up_addr[i*AW +: AW];
        sel_len   = up_burst_len[i*3 +: 3];
        sel_wdata = up_wdata[i*DW +: DW];
        sel_be    = up_byteenable[i*BW +: BW];
      end
    end
  end

  always_comb begin
    state_d        = state_q;
    grant_d        = grant_q;
    beats_d        = beats_q;
    fifo_push      = 1'b0;
    up_ready       = '0;
    bus_read       = 1'b0;
    bus_write      = 1'b0;
    bus_addr       = '0;
    bus_burst      = 1'b0;
    bus_burst_len  = '0;
    bus_wdata      = '0;
    bus_byteenable = '0;
    case (state_q)
      ST_IDLE: begin
        if (found) begin
          grant_d = win;
          beats_d = beats_f(win_burst, win_len);
          state_d = ST_GRANT;
        end
      end
      ST_GRANT: begin
        bus_read       = sel_read;
        bus_write      = sel_write;
        bus_addr       = sel_addr;
        bus_burst      = sel_burst;
        bus_burst_len  = sel_len;
        bus_wdata      = sel_wdata;
        bus_byteenable = sel_be;
        for (int i = 0; i < NPORT; i++) begin
          up_ready[i] = bus_ready & (grant_q == PORT_W'(i));
        end
        if (!sel_read && !sel_write) begin
          state_d = ST_IDLE;
        end else if (bus_ready) begin
          if (sel_read) begin
            fifo_push = 1'b1;
            state_d   = ST_IDLE;
          end else if (beats_q <= 4'd1) begin
            state_d = ST_IDLE;
          end else begin
            beats_d = beats_q - 1'b1;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rv_ok     = bus_rvalid & ~fifo_empty;
    up_rvalid = '0;
    up_rdata  = rv_ok ? bus_rdata : '0;
    fifo_pop  = 1'b0;
    rx_cnt_d  = rx_cnt_q;
    err_d     = err_q | (bus_rvalid & fifo_empty);
    for (int i = 0; i < NPORT; i++) begin
      up_rvalid[i] = rv_ok & (head.port == PORT_W'(i));
    end
    if (rv_ok) begin
      if (rx_cnt_q + 1'b1 >= head.beats) begin
        fifo_pop = 1'b1;
        rx_cnt_d = '0;
      end else begin
        rx_cnt_d = rx_cnt_q + 1'b1;
      end
    end
  end

  assign err_orphan_rvalid = err_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= ST_IDLE;
      grant_q  <= PORT_W'(NPORT - 1);
      beats_q  <= '0;
      rx_cnt_q <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      grant_q  <= grant_d;
      beats_q  <= beats_d;
      rx_cnt_q <= rx_cnt_d;
      err_q    <= err_d;
    end
  end

endmodule

// File: tb/tb_sdram_bus_arbiter.sv
// Directed bench for sdram_bus_arbiter: vector table for arbitration plus
// hand sequences for bursts, read routing, FIFO-full masking, orphan beats and reset.
module tb_sdram_bus_arbiter;

  localparam int NP = 4;
  localparam int AW = 23;
  localparam int DW = 16;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic [NP-1:0]        up_read, up_write, up_burst, up_ready, up_rvalid;
  logic [NP*AW-1:0]     up_addr;
  logic [NP*3-1:0]      up_burst_len;
  logic [NP*DW-1:0]     up_wdata;
  logic [NP*(DW/8)-1:0] up_byteenable;
  logic [DW-1:0]        up_rdata;
  logic                 bus_read, bus_write, bus_burst, bus_ready, bus_rvalid, err_orphan_rvalid;
  logic [AW-1:0]        bus_addr;
  logic [2:0]           bus_burst_len;
  logic [DW-1:0]        bus_wdata, bus_rdata;
  logic [DW/8-1:0]      bus_byteenable;

  sdram_bus_arbiter #(.NPORT(NP), .AW(AW), .DW(DW), .DEPTH(2)) dut (
    .clk(clk), .rst(rst),
    .up_read(up_read), .up_write(up_write), .up_addr(up_addr), .up_burst(up_burst),
    .up_burst_len(up_burst_len), .up_wdata(up_wdata), .up_byteenable(up_byteenable),
    .up_ready(up_ready), .up_rvalid(up_rvalid), .up_rdata(up_rdata),
    .bus_read(bus_read), .bus_write(bus_write), .bus_addr(bus_addr), .bus_burst(bus_burst),
    .bus_burst_len(bus_burst_len), .bus_wdata(bus_wdata), .bus_byteenable(bus_byteenable),
    .bus_ready(bus_ready), .bus_rvalid(bus_rvalid), .bus_rdata(bus_rdata),
    .err_orphan_rvalid(err_orphan_rvalid)
  );

  typedef struct {
    logic [3:0]  wr;
    logic [3:0]  exp_ready;
    logic        exp_bwrite;
    logic [22:0] exp_addr;
    logic [15:0] exp_wdata;
  } vec_t;

  vec_t tv [7];
  int total = 0;
  int bad   = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h want 0x%0h", nm, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic settle();
    #2;
  endtask

  task automatic set_wdata(input int p, input logic [15:0] v);
    up_wdata[p*DW +: DW] = v;
  endtask

  initial begin
    int beat;
    logic stall;

    up_read = '0; up_write = '0; up_burst = '0; up_burst_len = '0;
    up_byteenable = '1; bus_ready = 1'b1; bus_rvalid = 1'b0; bus_rdata = '0;
    for (int i = 0; i < NP; i++) begin
      up_addr[i*AW +: AW] = 23'((i + 1) * 256);
      set_wdata(i, 16'(16'hA000 + i));
    end

    tv[0] = '{4'b0101, 4'b0000, 1'b0, 23'h000, 16'h0000};
    tv[1] = '{4'b0101, 4'b0001, 1'b1, 23'h100, 16'hA000};
    tv[2] = '{4'b0101, 4'b0000, 1'b0, 23'h000, 16'h0000};
    tv[3] = '{4'b0101, 4'b0100, 1'b1, 23'h300, 16'hA002};
    tv[4] = '{4'b0001, 4'b0000, 1'b0, 23'h000, 16'h0000};
    tv[5] = '{4'b0001, 4'b0001, 1'b1, 23'h100, 16'hA000};
    tv[6] = '{4'b0000, 4'b0000, 1'b0, 23'h000, 16'h0000};

    #12;
    chk("rst_up_ready", up_ready, 0);
    chk("rst_up_rvalid", up_rvalid, 0);
    chk("rst_up_rdata", up_rdata, 0);
    chk("rst_bus_rw", {bus_read, bus_write, bus_burst}, 0);
    chk("rst_bus_addr", bus_addr, 0);
    chk("rst_err", err_orphan_rvalid, 0);
    @(negedge clk);
    rst = 1'b0;
    cyc();

    // Two single writes contending, port 0 re-requesting right away.
    for (int c = 0; c < 7; c++) begin
      up_write = tv[c].wr;
      settle();
      chk($sformatf("s1_ready[%0d]", c), up_ready, tv[c].exp_ready);
      chk($sformatf("s1_bwrite[%0d]", c), bus_write, tv[c].exp_bwrite);
      chk($sformatf("s1_addr[%0d]", c), bus_addr, tv[c].exp_addr);
      chk($sformatf("s1_wdata[%0d]", c), bus_wdata, tv[c].exp_wdata);
      cyc();
    end

    // Port 1 4-beat burst with one stall; port 3 waits throughout.
    up_write = 4'b1010; up_burst[1] = 1'b1; up_burst_len[5:3] = 3'd2;
    settle();
    chk("s2_idle_ready", up_ready, 0);
    cyc();
    beat = 0;
    for (int s = 0; s < 5; s++) begin
      stall = (s == 2);
      bus_ready = !stall;
      set_wdata(1, 16'(16'hC000 + beat));
      settle();
      chk($sformatf("s2_ready[%0d]", s), up_ready, stall ? 4'b0000 : 4'b0010);
      chk($sformatf("s2_bwrite[%0d]", s), bus_write, 1);
      chk($sformatf("s2_burst[%0d]", s), bus_burst, 1);
      chk($sformatf("s2_wdata[%0d]", s), bus_wdata, 16'(16'hC000 + beat));
      if (!stall) beat++;
      cyc();
    end
    up_write = 4'b1000; up_burst = '0; up_burst_len = '0; bus_ready = 1'b1;
    settle();
    chk("s2_bubble", up_ready, 0);
    cyc();
    settle();
    chk("s2_p3_ready", up_ready, 4'b1000);
    chk("s2_p3_addr", bus_addr, 23'h400);
    cyc();
    up_write = '0;
    settle();
    chk("s2_done", bus_write, 0);
    cyc();

    // Port 3 8-beat read, routed back only to port 3.
    up_read = 4'b1000; up_burst[3] = 1'b1; up_burst_len[11:9] = 3'd3;
    settle();
    chk("s3_idle", bus_read, 0);
    cyc();
    settle();
    chk("s3_bread", bus_read, 1);
    chk("s3_ready", up_ready, 4'b1000);
    chk("s3_len", bus_burst_len, 3);
    cyc();
    up_read = '0; up_burst = '0; up_burst_len = '0;
    for (int k = 0; k < 8; k++) begin
      bus_rvalid = 1'b1; bus_rdata = 16'(16'h1000 + k);
      settle();
      chk($sformatf("s3_rvalid[%0d]", k), up_rvalid, 4'b1000);
      chk($sformatf("s3_rdata[%0d]", k), up_rdata, 16'(16'h1000 + k));
      cyc();
    end
    bus_rvalid = 1'b0; bus_rdata = '0;

    // Depth-2 FIFO fills; port 3 read masked while port 0 write proceeds.
    up_read = 4'b1110;
    cyc();
    settle(); chk("s4_r1_ready", up_ready, 4'b0010); chk("s4_r1_bread", bus_read, 1);
    cyc(); up_read = 4'b1100;
    settle(); chk("s4_bubble", bus_read, 0);
    cyc();
    settle(); chk("s4_r2_ready", up_ready, 4'b0100);
    cyc(); up_read = 4'b1000; up_write = 4'b0001;
    settle(); chk("s4_idle", up_ready, 0);
    cyc();
    settle(); chk("s4_w0_ready", up_ready, 4'b0001); chk("s4_w0_bread", bus_read, 0);
    chk("s4_w0_bwrite", bus_write, 1);
    cyc(); up_write = '0;
    settle(); chk("s4_masked", {bus_read, up_ready}, 0);
    cyc(); bus_rvalid = 1'b1; bus_rdata = 16'h2001;
    settle(); chk("s4_ret1", up_rvalid, 4'b0010); chk("s4_ret1_data", up_rdata, 16'h2001);
    cyc(); bus_rvalid = 1'b0;
    settle(); chk("s4_still_masked", bus_read, 0);
    cyc();
    settle(); chk("s4_r3_ready", up_ready, 4'b1000); chk("s4_r3_bread", bus_read, 1);
    cyc(); up_read = '0; bus_rvalid = 1'b1; bus_rdata = 16'h2002;
    settle(); chk("s4_ret2", up_rvalid, 4'b0100);
    cyc(); bus_rdata = 16'h2003;
    settle(); chk("s4_ret3", up_rvalid, 4'b1000);
    cyc(); bus_rvalid = 1'b0;

    // Reads from 0, 1, 0 return in order.
    up_read = 4'b0011;
    cyc();
    settle(); chk("s5_r0_ready", up_ready, 4'b0001);
    cyc(); up_read = 4'b0010;
    cyc();
    settle(); chk("s5_r1_ready", up_ready, 4'b0010);
    cyc(); up_read = 4'b0001; bus_rvalid = 1'b1; bus_rdata = 16'h00B0;
    settle(); chk("s5_ret0", up_rvalid, 4'b0001); chk("s5_full_mask", bus_read, 0);
    cyc(); bus_rvalid = 1'b0;
    cyc();
    settle(); chk("s5_r0b_ready", up_ready, 4'b0001); chk("s5_r0b_bread", bus_read, 1);
    cyc(); up_read = '0; bus_rvalid = 1'b1; bus_rdata = 16'h00B1;
    settle(); chk("s5_ret1", up_rvalid, 4'b0010); chk("s5_ret1_data", up_rdata, 16'h00B1);
    cyc(); bus_rdata = 16'h00B2;
    settle(); chk("s5_ret2", up_rvalid, 4'b0001);
    cyc();

    // Orphan beat with empty FIFO.
    bus_rdata = 16'hDEAD;
    settle();
    chk("s6_orphan_rvalid", up_rvalid, 0);
    chk("s6_orphan_rdata", up_rdata, 0);
    chk("s6_err_same_cycle", err_orphan_rvalid, 0);
    cyc(); bus_rvalid = 1'b0; bus_rdata = '0;
    settle(); chk("s6_err_set", err_orphan_rvalid, 1);
    cyc(); cyc(); cyc();
    settle(); chk("s6_err_sticky", err_orphan_rvalid, 1);

    // Asynchronous reset in the middle of a write burst.
    up_write = 4'b0010; up_burst[1] = 1'b1; up_burst_len[5:3] = 3'd3;
    cyc();
    settle(); chk("s7_bwrite", bus_write, 1);
    #1 rst = 1'b1;
    #1;
    chk("s7_rst_ready", up_ready, 0);
    chk("s7_rst_bus", {bus_read, bus_write, bus_burst, bus_burst_len}, 0);
    chk("s7_rst_addr", bus_addr, 0);
    chk("s7_rst_wdata", bus_wdata, 0);
    chk("s7_rst_err", err_orphan_rvalid, 0);
    up_write = '0; up_burst = '0; up_burst_len = '0;
    cyc();
    rst = 1'b0;
    settle(); chk("s7_after_rst", {err_orphan_rvalid, up_ready, bus_write}, 0);
    cyc();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
